// File: rtl/fuzzy_dec_pkg.sv
// Shared types and helpers for the sequenced one-hot decoder.
// Helpers work on MAX_SEL_W-bit indices; callers cast to their own widths.
package fuzzy_dec_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DIRECT = 2'd1,
        SCAN   = 2'd2
    } dec_state_t;

    localparam int MAX_SEL_W = 8;
    localparam int MAX_OUT   = 2 ** MAX_SEL_W;

    function automatic logic [MAX_OUT-1:0] onehot(input logic [MAX_SEL_W-1:0] idx);
        logic [MAX_OUT-1:0] res;
        res      = '0;
        res[idx] = 1'b1;
        return res;
    endfunction

    // Reverses the low w bits of idx; bits above w come back zero.
    function automatic logic [MAX_SEL_W-1:0] bitrev(input logic [MAX_SEL_W-1:0] idx, input int w);
        logic [MAX_SEL_W-1:0] res;
        res = '0;
        for (int i = 0; i < MAX_SEL_W; i++) begin
            if (i < w) res = {res[MAX_SEL_W-2:0], idx[i]};
        end
        return res;
    endfunction

endpackage

// File: rtl/dec_dwell_timer.sv
// Dwell timer: o_tick pulses on every DWELL-th cycle that i_run is high.
// i_clr restarts the count from zero and suppresses the tick.
module dec_dwell_timer #(
    parameter int DWELL = 4
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_clr,
    input  logic i_run,
    output logic o_tick
);

    localparam int            CW   = $clog2(DWELL + 1);
    localparam logic [CW-1:0] LAST = CW'(DWELL - 1);

    logic [CW-1:0] r_cnt;

    assign o_tick = i_run & ~i_clr & (r_cnt == LAST);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_cnt <= '0;
        end else if (i_clr) begin
            r_cnt <= '0;
        end else if (i_run) begin
            r_cnt <= o_tick ? '0 : r_cnt + 1'b1;
        end
    end

endmodule

// File: rtl/seq_onehot_decoder.sv
// Registered SEL_W -> 2**SEL_W one-hot decoder with valid/ready input and an autonomous SCAN walk.
// SEQ_DEC_MSB_FIRST_EN: when defined, line indices are bit-reversed (legacy 3-to-8 mapping).
module seq_onehot_decoder
    import fuzzy_dec_pkg::*;
#(
    parameter int SEL_W = 3,
    parameter int DWELL = 4
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic                  i_en,
    input  logic                  i_mode,
    input  logic                  i_in_valid,
    output logic                  o_in_ready,
    input  logic [SEL_W-1:0]      i_sel,
    output logic [2**SEL_W-1:0]   o_out,
    output logic                  o_out_valid,
    output logic                  o_scan_wrap
);

    localparam int NUM_OUT = 2 ** SEL_W;

    dec_state_t         r_state;
    dec_state_t         w_state_nxt;
    logic [SEL_W-1:0]   r_idx;
    logic [SEL_W-1:0]   r_pend_line;
    logic               r_pend_vld;
    logic [NUM_OUT-1:0] r_out;
    logic               r_out_valid;
    logic               r_scan_wrap;

    logic               w_accept;
    logic               w_scan_run;
    logic               w_scan_enter;
    logic               w_tick;
    logic [SEL_W-1:0]   w_idx_inc;
    logic [SEL_W-1:0]   w_sel_line;
    logic [SEL_W-1:0]   w_scan_line;
    logic [NUM_OUT-1:0] w_sel_oh;
    logic [NUM_OUT-1:0] w_scan_oh;
    logic [NUM_OUT-1:0] w_pend_oh;

    assign w_idx_inc = r_idx + 1'b1;

`ifdef SEQ_DEC_MSB_FIRST_EN
    assign w_sel_line  = SEL_W'(bitrev(MAX_SEL_W'(i_sel), SEL_W));
    assign w_scan_line = SEL_W'(bitrev(MAX_SEL_W'(w_idx_inc), SEL_W));
`else
    assign w_sel_line  = i_sel;
    assign w_scan_line = w_idx_inc;
`endif

    assign w_sel_oh  = NUM_OUT'(onehot(MAX_SEL_W'(w_sel_line)));
    assign w_scan_oh = NUM_OUT'(onehot(MAX_SEL_W'(w_scan_line)));
    assign w_pend_oh = NUM_OUT'(onehot(MAX_SEL_W'(r_pend_line)));

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) r_state <= IDLE;
        else          r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = IDLE;
        if (i_en) w_state_nxt = i_mode ? SCAN : DIRECT;
    end

    always_comb begin
        o_in_ready   = i_rst_n & i_en & ~i_mode;
        w_accept     = o_in_ready & i_in_valid;
        w_scan_run   = (r_state == SCAN) & i_en & i_mode;
        w_scan_enter = (r_state != SCAN) & i_en & i_mode;
    end

    dec_dwell_timer #(.DWELL(DWELL)) u_dwell (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_clr   (~w_scan_run),
        .i_run   (w_scan_run),
        .o_tick  (w_tick)
    );

    // An accept in the SCAN->DIRECT switch cycle is parked one cycle so the line first reads zero.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_idx       <= '0;
            r_pend_line <= '0;
            r_pend_vld  <= 1'b0;
            r_out       <= '0;
            r_out_valid <= 1'b0;
            r_scan_wrap <= 1'b0;
        end else begin
            r_scan_wrap <= 1'b0;
            r_pend_vld  <= 1'b0;
            case (w_state_nxt)
                SCAN: begin
                    if (w_scan_enter) begin
                        r_idx       <= '0;
                        r_out       <= NUM_OUT'(1);
                        r_out_valid <= 1'b1;
                    end else if (w_tick) begin
                        r_idx       <= w_idx_inc;
                        r_out       <= w_scan_oh;
                        r_scan_wrap <= &r_idx;
                    end
                end
                DIRECT: begin
                    r_idx <= '0;
                    if (r_state == SCAN) begin
                        r_out       <= '0;
                        r_out_valid <= 1'b0;
                        r_pend_vld  <= w_accept;
                        r_pend_line <= w_sel_line;
                    end else if (w_accept) begin
                        r_out       <= w_sel_oh;
                        r_out_valid <= 1'b1;
                    end else if (r_pend_vld) begin
                        r_out       <= w_pend_oh;
                        r_out_valid <= 1'b1;
                    end
                end
                default: begin
                    r_idx       <= '0;
                    r_out       <= '0;
                    r_out_valid <= 1'b0;
                end
            endcase
        end
    end

    assign o_out       = r_out;
    assign o_out_valid = r_out_valid;
    assign o_scan_wrap = r_scan_wrap;

endmodule
